// File: rtl/caches_pkg.sv
// Shared cache/memory types: the arbiter-facing RAM status and the
// memory controller's internal FSM encoding.
package caches_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} ram_ctrl_state_t;

endpackage

// File: rtl/ram_access_ctrl_ram_word_array.sv
// Word-wide backing store: synchronous write, combinational read.
// Contents are intentionally not reset.
module ram_word_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_access_ctrl.sv
// Fixed-latency word-addressed memory model behind the arbiter's single RAM port,
// with saturating completed-read/write counters.
module ram_access_ctrl
    import caches_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned LAT    = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ramREN,
    input  logic              ramWEN,
    input  logic [ADDR_W-1:0] ramaddr,
    input  logic [DATA_W-1:0] ramstore,
    output logic [DATA_W-1:0] ramload,
    output ramstate_t         ramstate,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [3:0]  LAT_C = 4'(LAT);

    ram_ctrl_state_t   state_q, state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        cnt_q, cnt_d;

    logic              req, illegal, changed, start;
    logic              latch_en, load_en, mem_we;
    logic [ADDR_W-1:0] word_full;
    logic [IDX_W-1:0]  cur_idx, lat_idx, rd_idx;
    logic [DATA_W-1:0] rd_data;

    assign req       = ramREN | ramWEN;
    assign word_full = ramaddr >> 2;
    assign illegal   = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                       (word_full >= ADDR_W'(DEPTH));
    assign cur_idx   = ramaddr[IDX_W+1:2];
    assign lat_idx   = addr_q[IDX_W+1:2];
    // Any difference from the latched transaction restarts the access.
    assign changed   = (ramWEN != wr_q) | (ramaddr != addr_q) |
                       (ramWEN & (ramstore != data_q));
    assign mem_we    = (state_q == ACC) & wr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start    = 1'b0;
        latch_en = 1'b0;
        load_en  = 1'b0;
        rd_idx   = lat_idx;
        ramstate = FREE;
        unique case (state_q)
            IDLE: begin
                ramstate = FREE;
                start    = req;
            end
            WAIT: begin
                ramstate = BUSY;
                if (!req) begin
                    state_d = IDLE;
                end else if (changed) begin
                    start = 1'b1;
                end else if (cnt_q == 4'd1) begin
                    state_d = ACC;
                    load_en = ~wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACC: begin
                ramstate = ACCESS;
                state_d  = IDLE;
            end
            ERR: begin
                ramstate = ERROR;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            if (illegal) begin
                state_d = ERR;
            end else begin
                latch_en = 1'b1;
                cnt_d    = LAT_C;
                rd_idx   = cur_idx;
                if (LAT_C == 4'd0) begin
                    state_d = ACC;
                    load_en = ramREN;
                end else begin
                    state_d = WAIT;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            ramload  <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                wr_q   <= ramWEN;
                addr_q <= ramaddr;
                data_q <= ramstore;
            end
            if (load_en) ramload <= rd_data;
            if (state_q == ACC) begin
                if (wr_q && wr_count != '1) wr_count <= wr_count + 1'b1;
                if (!wr_q && rd_count != '1) rd_count <= rd_count + 1'b1;
            end
        end
    end

    ram_word_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (lat_idx),
        .wdata (data_q),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench: LAT=2/CNT_W=4 instance for the main sequence, LAT=0 instance
// for the zero-latency path.
module tb_ram_access_ctrl;
    import caches_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    ramstate_t   ramstate;
    logic [3:0]  rd_count, wr_count;

    logic        z_ren, z_wen;
    logic [31:0] z_addr, z_store, z_load;
    ramstate_t   z_state;
    logic [15:0] z_rd, z_wr;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    ram_access_ctrl #(.LAT(2), .CNT_W(4)) u_dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    ram_access_ctrl #(.LAT(0)) u_lat0 (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (z_ren),
        .ramWEN   (z_wen),
        .ramaddr  (z_addr),
        .ramstore (z_store),
        .ramload  (z_load),
        .ramstate (z_state),
        .rd_count (z_rd),
        .wr_count (z_wr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        ramWEN = 1'b1; ramaddr = a; ramstore = d;
        step(); check("wr busy1", 32'(ramstate), 32'(BUSY));
        step(); check("wr busy2", 32'(ramstate), 32'(BUSY));
        step(); check("wr access", 32'(ramstate), 32'(ACCESS));
        ramWEN = 1'b0;
        step(); check("wr free", 32'(ramstate), 32'(FREE));
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d);
        ramREN = 1'b1; ramaddr = a;
        step(); check("rd busy1", 32'(ramstate), 32'(BUSY));
        step(); check("rd busy2", 32'(ramstate), 32'(BUSY));
        step(); check("rd access", 32'(ramstate), 32'(ACCESS));
        check("rd data", ramload, d);
        ramREN = 1'b0;
        step(); check("rd free", 32'(ramstate), 32'(FREE));
    endtask

    initial begin
        ramREN = 0; ramWEN = 0; ramaddr = 0; ramstore = 0;
        z_ren = 0; z_wen = 0; z_addr = 0; z_store = 0;
        nRST = 1'b0;
        repeat (3) step();
        nRST = 1'b1;
        step();
        check("reset state", 32'(ramstate), 32'(FREE));
        check("reset load", ramload, 32'h0);
        check("reset rd", 32'(rd_count), 32'd0);
        check("reset wr", 32'(wr_count), 32'd0);

        // Reset in the middle of a write must not commit it.
        do_write(32'h10, 32'h1111_1111);
        check("wr count pre", 32'(wr_count), 32'd1);
        ramWEN = 1'b1; ramaddr = 32'h10; ramstore = 32'h2222_2222;
        step(); check("mid busy", 32'(ramstate), 32'(BUSY));
        nRST = 1'b0;
        #1;
        check("async reset", 32'(ramstate), 32'(FREE));
        check("reset wr clr", 32'(wr_count), 32'd0);
        #2;
        nRST = 1'b1; ramWEN = 1'b0;
        step(); check("post reset", 32'(ramstate), 32'(FREE));
        do_read(32'h10, 32'h1111_1111);
        check("rd count 1", 32'(rd_count), 32'd1);

        do_write(32'h40, 32'hDEAD_BEEF);
        check("wr count 1", 32'(wr_count), 32'd1);
        do_read(32'h40, 32'hDEAD_BEEF);
        check("rd count 2", 32'(rd_count), 32'd2);

        // Address switch during WAIT restarts the latency.
        do_write(32'h8, 32'h0000_000A);
        do_write(32'hC, 32'h0000_000B);
        ramREN = 1'b1; ramaddr = 32'h8;
        step(); check("sw busy0", 32'(ramstate), 32'(BUSY));
        ramaddr = 32'hC;
        step(); check("sw busy1", 32'(ramstate), 32'(BUSY));
        step(); check("sw busy2", 32'(ramstate), 32'(BUSY));
        step(); check("sw access", 32'(ramstate), 32'(ACCESS));
        check("sw data", ramload, 32'h0000_000B);
        ramREN = 1'b0;
        step(); check("rd count 3", 32'(rd_count), 32'd3);

        // Request dropped in WAIT.
        ramREN = 1'b1; ramaddr = 32'h8;
        step(); check("drop busy", 32'(ramstate), 32'(BUSY));
        ramREN = 1'b0;
        step(); check("drop idle", 32'(ramstate), 32'(FREE));
        step(); check("drop rd cnt", 32'(rd_count), 32'd3);
        check("drop load", ramload, 32'h0000_000B);

        // Illegal requests.
        ramREN = 1'b1; ramaddr = 32'h41;
        step(); check("misalign err", 32'(ramstate), 32'(ERROR));
        ramREN = 1'b0;
        step(); check("misalign free", 32'(ramstate), 32'(FREE));
        check("misalign rd", 32'(rd_count), 32'd3);
        ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h40; ramstore = 32'h5555_5555;
        step(); check("both err", 32'(ramstate), 32'(ERROR));
        ramREN = 1'b0; ramWEN = 1'b0;
        step(); check("both free", 32'(ramstate), 32'(FREE));
        check("both wr", 32'(wr_count), 32'd3);
        do_read(32'h40, 32'hDEAD_BEEF);
        ramREN = 1'b1; ramaddr = 32'h1000;
        step(); check("range err", 32'(ramstate), 32'(ERROR));
        ramREN = 1'b0;
        step(); check("range free", 32'(ramstate), 32'(FREE));
        check("rd count 4", 32'(rd_count), 32'd4);

        // Held request: a new access every LAT+2 cycles, then saturation.
        ramREN = 1'b1; ramaddr = 32'h40;
        for (int i = 0; i < 8; i++) begin
            ramstate_t exp_st;
            step();
            exp_st = (i % 4 == 2) ? ACCESS : (i % 4 == 3) ? FREE : BUSY;
            check("held state", 32'(ramstate), 32'(exp_st));
        end
        check("held rd", 32'(rd_count), 32'd6);
        repeat (60) step();
        ramREN = 1'b0;
        step();
        check("sat rd", 32'(rd_count), 32'd15);
        check("sat wr", 32'(wr_count), 32'd3);
        check("sat load", ramload, 32'hDEAD_BEEF);

        // Zero-latency instance.
        check("l0 reset load", z_load, 32'h0);
        z_wen = 1'b1; z_addr = 32'h0; z_store = 32'h1234_5678;
        step(); check("l0 wr access", 32'(z_state), 32'(ACCESS));
        z_wen = 1'b0;
        step(); check("l0 wr free", 32'(z_state), 32'(FREE));
        check("l0 wr cnt", 32'(z_wr), 32'd1);
        z_ren = 1'b1;
        step(); check("l0 rd access", 32'(z_state), 32'(ACCESS));
        check("l0 rd data", z_load, 32'h1234_5678);
        step(); check("l0 held free", 32'(z_state), 32'(FREE));
        step(); check("l0 held access", 32'(z_state), 32'(ACCESS));
        z_ren = 1'b0;
        step(); check("l0 rd cnt", 32'(z_rd), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Memory-side controller directly downstream of the memory arbiter.
- Accepts the arbiter's single-port RAM request (ramREN/ramWEN/ramaddr/ramstore) and models a fixed-latency word-addressed memory.
- Reports progress through ramstate (FREE/BUSY/ACCESS/ERROR) and returns read data on ramload.
- The arbiter completes a transfer in the cycle ramstate==ACCESS.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.
- DEPTH, 1024, number of words in the backing array.
- LAT, 2, BUSY cycles before ACCESS (legal 0..15).
- CNT_W, 16, width of the saturating perf counters.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- ramREN  in  1  read request, level, held until ACCESS seen.
- ramWEN  in  1  write request, level, held until ACCESS seen.
- ramaddr  in  ADDR_W  byte address.
- ramstore  in  DATA_W  write data.
- ramload  out  DATA_W  read data, valid in ACCESS cycle of a read.
- ramstate  out  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- rd_count  out  CNT_W  completed reads, saturating.
- wr_count  out  CNT_W  completed writes, saturating.

Behaviour:
- One clock CLK; reset nRST is asynchronous, active-low.
- Reset values: FSM=IDLE, ramstate=FREE, ramload=0, rd_count=0, wr_count=0, latch/counter=0. Array contents are not cleared.
- Reset mid-operation aborts the access; a pending write is not committed.
- Request is req = ramREN|ramWEN.
- Illegal request = both REN and WEN, or ramaddr[1:0]!=0, or word index ramaddr>>2 >= DEPTH.
- FSM states and transitions:
  - IDLE: ramstate=FREE.
    - Legal req at cycle t: latch op/addr/data, load cnt=LAT. Next state is WAIT if LAT>0, else ACC.
    - Illegal req: next state ERR.
  - WAIT: ramstate=BUSY; cnt decrements each cycle.
    - When cnt==1, next is ACC; at the same edge, for a read, ramload <= mem[word].
    - Request dropped: return to IDLE; nothing committed.
    - Request changed (op, addr or, for writes, data differs from latch): abort, relatch, reload cnt=LAT, stay in WAIT (or go to ACC if LAT==0).
  - ACC: ramstate=ACCESS for exactly one cycle.
    - Write commits mem[word]<=latched data at the closing edge.
    - rd_count or wr_count increments by 1 and saturates at all-ones.
    - Next state is IDLE unconditionally. A request still held in the following cycle is treated as a new request.
  - ERR: ramstate=ERROR for one cycle; no array access, counters unchanged; next state IDLE.
- Timing:
  - With LAT=0 the read data arrives combinationally from the LAT==0 load at the IDLE→ACC edge, so ACCESS occurs at t+1.
  - In general, ACCESS occurs at cycle t+LAT+1.
- ramload holds its last value outside read ACCESS cycles. It is never updated by writes or ERROR.
- Read-after-write to the same word in back-to-back transactions returns the new data, because the commit precedes the next latch.
- Request arriving in the ACC or ERR cycle is ignored; it is sampled only from IDLE.

Decomposition:
- caches_pkg (shared) holds:
  - ramstate_t enum {FREE, BUSY, ACCESS, ERROR}; this is the existing type used by the arbiter and must not be redefined.
  - local FSM enum ram_ctrl_state_t {IDLE, WAIT, ACC, ERR}.
- One sub-module, ram_word_array: DEPTH×DATA_W storage with a synchronous write and a read port.
- Latency counter, latch and perf counters stay in ram_access_ctrl.

Test Plan:
- Reset with LAT=2, idle → ramstate=FREE, ramload=0, counts=0. Assert nRST low mid-WAIT of a write to 0x10; after release, read 0x10 returns its old value.
- Write: ramWEN=1, addr=0x40, store=0xDEADBEEF at t → BUSY at t+1,t+2, ACCESS at t+3, wr_count=1. Then read 0x40 → ACCESS at t'+3 with ramload=0xDEADBEEF, rd_count=1.
- LAT=0 build: read 0x0 after writing 0x12345678 → ACCESS on the cycle after request, ramload=0x12345678.
- Address change in WAIT: read 0x8 for 1 cycle, then switch to 0xC → BUSY restarts, ACCESS 3 cycles after the switch, data from 0xC. Request dropped in WAIT → IDLE, counts unchanged.
- Illegal: addr=0x41 → ERROR for 1 cycle then FREE. REN&WEN=1 → ERROR, array unchanged. addr=0x1000 (DEPTH=1024) → ERROR.
- Saturation with CNT_W=4: 17 reads → rd_count stays 15. Request held continuously → a new access starts every LAT+2 cycles.
